// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/multiply-divide unit: MIPS opcode and funct
// values, controller states, operation classes and flag bit positions.
package alu_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } alu_state_e;

    // How a decoded instruction is executed
    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MUL = 2'd1,
        CLS_DIV = 2'd2
    } op_class_e;

    // Bit positions inside the flags output
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative shift-add multiplier and restoring divider. Works on operand
// magnitudes and fixes signs at the output. The divide step exists only
// when ALU_DIV_EN is defined; otherwise divide starts are ignored.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opb;
    logic             neg_lo;
    logic             go;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] mq_n;
    logic [2*WIDTH-1:0] prod;

`ifdef ALU_DIV_EN
    logic             div_r;
    logic             neg_rem;
    logic             div0;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH:0]   trial;
    assign go = start;
`else
    assign go = start & ~mode_div;
`endif

    assign sa    = is_signed & a[WIDTH-1];
    assign sb    = is_signed & b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    // One iteration step: shift-add for multiply, restoring step for divide
    always_comb begin
        mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
        acc_n   = mul_sum[WIDTH:1];
        mq_n    = {mul_sum[0], mq[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        trial = {acc, mq[WIDTH-1]} - {1'b0, opb};
        if (div_r) begin
            if (!trial[WIDTH]) begin
                acc_n = trial[WIDTH-1:0];
                mq_n  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = {acc[WIDTH-2:0], mq[WIDTH-1]};
                mq_n  = {mq[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Iteration control: WIDTH steps after start, then a one-cycle done
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else if (go) begin
            busy <= 1'b1;
            done <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    // Operand load on start, then one step per cycle while busy
    always_ff @(posedge clk) begin
        if (go) begin
            acc    <= '0;
            mq     <= mag_a;
            opb    <= mag_b;
            neg_lo <= sa ^ sb;
`ifdef ALU_DIV_EN
            div_r   <= mode_div;
            neg_rem <= sa;
            div0    <= (b == '0);
            a_r     <= a;
`endif
        end else if (busy) begin
            acc <= acc_n;
            mq  <= mq_n;
        end
    end

    assign prod = neg_lo ? -{acc, mq} : {acc, mq};

    // Sign correction and divide-by-zero override on the final values
    always_comb begin
        hi = prod[2*WIDTH-1:WIDTH];
        lo = prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
        if (div_r) begin
            if (div0) begin
                hi = a_r;
                lo = '1;
            end else begin
                hi = neg_rem ? -acc : acc;
                lo = neg_lo ? -mq : mq;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_mdu.sv
// MIPS-style ALU with iterative multiply/divide and HI/LO registers.
// One operation in flight; single-cycle ops answer one cycle after
// acceptance, mult/div after WIDTH+1 cycles. Define ALU_DIV_EN to build
// the divider; without it div/divu decode as undefined instructions.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e state;
    alu_state_e state_n;
    op_class_e  cls;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic signed [15:0] imm_s;
    logic signed [WIDTH-1:0] imm_sx;
    logic [WIDTH-1:0] imm_zx;
    logic signed [WIDTH-1:0] sa_v;
    logic signed [WIDTH-1:0] sb_v;
    logic [SHW-1:0]   vamt;
    logic [WIDTH-1:0] sum_rr;
    logic [WIDTH-1:0] dif_rr;
    logic [WIDTH-1:0] sum_ri;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             sgn;
    logic             accept;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             it_done;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;
    logic             unused_bits;

    function automatic logic [2:0] mk_flags(input logic [WIDTH-1:0] r, input logic v);
        logic [2:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_V] = v;
        return f;
    endfunction

    function automatic logic add_ovf(input logic [WIDTH-1:0] a, b, s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] a, b, d);
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign opcode      = instruction[31:26];
    assign funct       = instruction[5:0];
    assign shamt       = instruction[10:6];
    assign imm         = instruction[15:0];
    assign unused_bits = ^instruction[25:16];
    assign imm_s       = imm;
    assign imm_sx      = WIDTH'(imm_s);
    assign imm_zx      = WIDTH'(imm);
    assign sa_v        = regA;
    assign sb_v        = regB;
    assign vamt        = regA[SHW-1:0];
    assign sum_rr      = regA + regB;
    assign dif_rr      = regA - regB;
    assign sum_ri      = regA + imm_sx;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Instruction decode and single-cycle result
    always_comb begin
        cls     = CLS_ALU;
        alu_res = '0;
        alu_ovf = 1'b0;
        sgn     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:   alu_res = regB << shamt;
                    FN_SRL:   alu_res = regB >> shamt;
                    FN_SRA:   alu_res = sb_v >>> shamt;
                    FN_SLLV:  alu_res = regB << vamt;
                    FN_SRLV:  alu_res = regB >> vamt;
                    FN_SRAV:  alu_res = sb_v >>> vamt;
                    FN_MFHI:  alu_res = hi;
                    FN_MFLO:  alu_res = lo;
                    FN_MULT: begin
                        cls = CLS_MUL;
                        sgn = 1'b1;
                    end
                    FN_MULTU: cls = CLS_MUL;
`ifdef ALU_DIV_EN
                    FN_DIV: begin
                        cls = CLS_DIV;
                        sgn = 1'b1;
                    end
                    FN_DIVU:  cls = CLS_DIV;
`endif
                    FN_ADD: begin
                        alu_res = sum_rr;
                        alu_ovf = add_ovf(regA, regB, sum_rr);
                    end
                    FN_ADDU:  alu_res = sum_rr;
                    FN_SUB: begin
                        alu_res = dif_rr;
                        alu_ovf = sub_ovf(regA, regB, dif_rr);
                    end
                    FN_SUBU:  alu_res = dif_rr;
                    FN_AND:   alu_res = regA & regB;
                    FN_OR:    alu_res = regA | regB;
                    FN_XOR:   alu_res = regA ^ regB;
                    FN_NOR:   alu_res = ~(regA | regB);
                    FN_SLT:   alu_res = WIDTH'(sa_v < sb_v);
                    FN_SLTU:  alu_res = WIDTH'(regA < regB);
                    default:  alu_res = '0;
                endcase
            end
            OP_ADDI: begin
                alu_res = sum_ri;
                alu_ovf = add_ovf(regA, imm_sx, sum_ri);
            end
            OP_ADDIU: alu_res = sum_ri;
            OP_SLTI:  alu_res = WIDTH'(sa_v < imm_sx);
            OP_SLTIU: alu_res = WIDTH'(regA < WIDTH'(imm_sx));
            OP_ANDI:  alu_res = regA & imm_zx;
            OP_ORI:   alu_res = regA | imm_zx;
            OP_XORI:  alu_res = regA ^ imm_zx;
            OP_LUI:   alu_res = imm_zx << 16;
            default:  alu_res = '0;
        endcase
    end

    alu_mdu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (accept && (cls != CLS_ALU)),
        .mode_div (cls == CLS_DIV),
        .is_signed(sgn),
        .a        (regA),
        .b        (regB),
        .done     (it_done),
        .hi       (it_hi),
        .lo       (it_lo)
    );

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state: leave IDLE for multi-cycle ops, return when the iterator finishes
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept && cls == CLS_MUL)      state_n = MUL;
                else if (accept && cls == CLS_DIV) state_n = DIV;
            end
            MUL, DIV: if (it_done) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Output register and HI/LO; results hold until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (it_done && state != IDLE) begin
                hi        <= it_hi;
                lo        <= it_lo;
                result    <= it_lo;
                flags     <= mk_flags(it_lo, 1'b0);
                out_valid <= 1'b1;
            end else if (accept && cls == CLS_ALU) begin
                result    <= alu_res;
                flags     <= mk_flags(alu_res, alu_ovf);
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (WIDTH=32): table of single-cycle vectors plus
// hand-written multiply/divide, back-pressure and reset-abort sequences.
module tb_alu_mdu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] regA;
    logic [31:0] regB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs[$];

    alu_mdu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instruction(instruction),
        .regA       (regA),
        .regB       (regB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] sh);
        return {6'h00, 15'd0, sh, fn};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'd0, imm};
    endfunction

    task automatic addv(input logic [31:0] ins, a, b, res, input logic [2:0] flg);
        vec_t v;
        v.ins = ins; v.a = a; v.b = b; v.res = res; v.flg = flg;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Offer an op at the falling edge, wait (bounded) for acceptance, return #1 after the accepting edge
    task automatic issue(input logic [31:0] ins, a, b);
        int n;
        n = 0;
        @(negedge clk);
        instruction = ins; regA = a; regB = b; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready low for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic single(input string nm, input logic [31:0] ins, a, b, res, input logic [2:0] flg);
        issue(ins, a, b);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_result"}, result, res);
        chk({nm, "_flags"}, {29'd0, flags}, {29'd0, flg});
    endtask

    task automatic multi(input string nm, input logic [31:0] ins, a, b, res, input logic [2:0] flg);
        int n;
        issue(ins, a, b);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk({nm, "_latency"}, n, 32'd33);
        chk({nm, "_result"}, result, res);
        chk({nm, "_flags"}, {29'd0, flags}, {29'd0, flg});
    endtask

    initial begin
        int bad;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        instruction = '0; regA = '0; regB = '0;

        addv(rt(6'h10, 0), 32'h0, 32'h0, 32'h0, 3'b100);                          // mfhi after reset
        addv(rt(6'h21, 0), 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 3'b010);     // addu
        addv(it(6'h09, 16'h7FFF), 32'h7FFFFFFF, 32'h0, 32'h80007FFE, 3'b010);     // addiu
        addv(it(6'h08, 16'h7FFF), 32'h7FFFFFFF, 32'h0, 32'h80007FFE, 3'b011);     // addi overflow
        addv(rt(6'h20, 0), 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b011);     // add overflow
        addv(rt(6'h20, 0), 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b100);     // add no overflow
        addv(rt(6'h22, 0), 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b001);     // sub overflow
        addv(rt(6'h23, 0), 32'h00000005, 32'h00000005, 32'h00000000, 3'b100);     // subu
        addv(rt(6'h24, 0), 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 3'b010);     // and
        addv(rt(6'h25, 0), 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 3'b000);     // or
        addv(rt(6'h26, 0), 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 3'b000);     // xor
        addv(rt(6'h27, 0), 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 3'b010);     // nor
        addv(rt(6'h2A, 0), 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 3'b000);     // slt
        addv(rt(6'h2B, 0), 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b100);     // sltu
        addv(rt(6'h00, 31), 32'h0, 32'h00000001, 32'h80000000, 3'b010);           // sll
        addv(rt(6'h02, 4), 32'h0, 32'h80000000, 32'h08000000, 3'b000);            // srl
        addv(rt(6'h03, 4), 32'h0, 32'h80000000, 32'hF8000000, 3'b010);            // sra
        addv(rt(6'h04, 0), 32'h00000024, 32'h00000003, 32'h00000030, 3'b000);     // sllv (amount masked to 4)
        addv(rt(6'h06, 0), 32'h00000001, 32'h00000010, 32'h00000008, 3'b000);     // srlv
        addv(rt(6'h07, 0), 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 3'b010);     // srav
        addv(it(6'h0C, 16'h8000), 32'hFFFFFFFF, 32'h0, 32'h00008000, 3'b000);     // andi zero-extends
        addv(it(6'h0D, 16'hFFFF), 32'h00000000, 32'h0, 32'h0000FFFF, 3'b000);     // ori
        addv(it(6'h0E, 16'hFFFF), 32'h0000FFFF, 32'h0, 32'h00000000, 3'b100);     // xori
        addv(it(6'h0A, 16'hFFFF), 32'h00000000, 32'h0, 32'h00000000, 3'b100);     // slti 0 < -1
        addv(it(6'h0B, 16'hFFFF), 32'h00000000, 32'h0, 32'h00000001, 3'b000);     // sltiu 0 < 0xFFFFFFFF
        addv(it(6'h0F, 16'h1234), 32'h0, 32'h0, 32'h12340000, 3'b000);            // lui
        addv(it(6'h3F, 16'h1234), 32'h5, 32'h7, 32'h00000000, 3'b100);            // undecoded

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, flags}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single-cycle table
        for (int i = 0; i < vecs.size(); i++) begin
            single($sformatf("vec%0d", i), vecs[i].ins, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg);
        end

        // Multiply and HI/LO readback
        multi("mult", rt(6'h18, 0), 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 3'b010);
        single("mfhi_mult", rt(6'h10, 0), 32'h0, 32'h0, 32'hFFFFFFFF, 3'b010);
        single("mflo_mult", rt(6'h12, 0), 32'h0, 32'h0, 32'hFFFFFFF1, 3'b010);
        multi("multu", rt(6'h19, 0), 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 3'b010);
        single("mfhi_multu", rt(6'h10, 0), 32'h0, 32'h0, 32'h00000001, 3'b000);

`ifdef ALU_DIV_EN
        multi("div", rt(6'h1A, 0), 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 3'b010);
        single("mfhi_div", rt(6'h10, 0), 32'h0, 32'h0, 32'h00000001, 3'b000);
        multi("divu0", rt(6'h1B, 0), 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 3'b010);
        single("mfhi_divu0", rt(6'h10, 0), 32'h0, 32'h0, 32'h00000007, 3'b000);
`else
        single("div_off", rt(6'h1A, 0), 32'h00000007, 32'hFFFFFFFE, 32'h00000000, 3'b100);
        single("divu_off", rt(6'h1B, 0), 32'h00000007, 32'h00000000, 32'h00000000, 3'b100);
        single("mfhi_div_off", rt(6'h10, 0), 32'h0, 32'h0, 32'h00000001, 3'b000);
        single("mflo_div_off", rt(6'h12, 0), 32'h0, 32'h0, 32'hFFFFFFFE, 3'b010);
`endif

        // Back-pressure: result held while out_ready is low
        issue(rt(6'h24, 0), 32'hFFFF0000, 32'h8000FFFF);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", result, 32'h80000000);
            chk("hold_flags", {29'd0, flags}, {29'd0, 3'b010});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        // Release and accept a new op on the same edge
        @(negedge clk);
        out_ready = 1'b1;
        instruction = rt(6'h25, 0); regA = 32'h1; regB = 32'h2; in_valid = 1'b1;
        #1 chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("release_valid", {31'd0, out_valid}, 32'd1);
        chk("release_result", result, 32'h00000003);
        chk("release_flags", {29'd0, flags}, 32'd0);

        // Reset ten cycles into a multiply
        issue(rt(6'h18, 0), 32'h00000003, 32'h00000005);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1 if (out_valid) bad++;
        end
        chk("abort_no_valid", bad, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        single("mflo_after_abort", rt(6'h12, 0), 32'h0, 32'h0, 32'h00000000, 3'b100);
        single("mfhi_after_abort", rt(6'h10, 0), 32'h0, 32'h0, 32'h00000000, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal values are 16, 32 and 64.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation offered.
REQ-005 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-006 SHALL have port instruction  input  32  MIPS instruction word (opcode [31:26], funct [5:0], shamt [10:6], imm [15:0]).
REQ-007 SHALL have ports regA, regB  input  WIDTH  rs and rt operand values.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-010 SHALL have port result  output  WIDTH  operation result.
REQ-011 SHALL have port flags  output  3  {zero, negative, overflow} = flags[2], flags[1], flags[0].

Function
REQ-012 SHALL support add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, addi, addiu, andi, ori, xori, slti, sltiu, lui, mult, multu, div, divu, mfhi, mflo.
REQ-013 SHALL sign-extend imm to WIDTH for addi/addiu/slti/sltiu and zero-extend it for andi/ori/xori; lui yields imm << 16.
REQ-014 SHALL set overflow only for add, sub and addi on signed overflow; all other ops drive overflow 0; the result is still written.
REQ-015 SHALL drive zero = (result == 0) and negative = result[WIDTH-1] for every completed op.
REQ-016 SHALL use variable shift amount regA[log2(WIDTH)-1:0]; shamt for fixed shifts.
REQ-017 SHALL accept at most one operation in flight: in_ready = state IDLE && (!out_valid || out_ready).
REQ-018 SHALL implement state machine IDLE, MUL, DIV; single-cycle ops stay in IDLE; mult/multu enter MUL, div/divu enter DIV; both return to IDLE after WIDTH iterations.
REQ-019 SHALL present single-cycle results with out_valid asserted on the cycle after acceptance (latency 1).
REQ-020 SHALL complete mult/multu/div/divu with out_valid asserted WIDTH+1 cycles after acceptance, result = new LO.
REQ-021 SHALL hold result, flags and out_valid stable until out_ready; accepting a new op in the same cycle as the handshake is allowed.
REQ-022 SHALL write HI/LO only on mult/div completion; mult: {HI,LO} = 2*WIDTH-bit product; div: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-023 SHALL on divide by zero set LO = all ones, HI = regA, overflow 0.
REQ-024 SHALL return HI/LO for mfhi/mflo, reflecting any previously completed mult/div.
REQ-025 SHALL treat an undecoded instruction as single-cycle, result 0, flags 3'b100, HI/LO unchanged.

Reset
REQ-026 SHALL on rst set state IDLE, out_valid 0, result 0, flags 0, HI 0, LO 0, iteration counter 0.
REQ-027 SHALL abort an in-progress mult/div on rst with no HI/LO update and no out_valid.
REQ-028 SHALL give rst priority over every simultaneous handshake.

Configuration
REQ-029 SHALL compile the iterative divider only when ALU_DIV_EN is defined.
REQ-030 SHALL without ALU_DIV_EN treat div/divu per REQ-025 (latency 1, HI/LO unchanged); mult/multu unaffected.

Structure
REQ-031 SHALL place opcode/funct constants, state encoding and flag bit indices in shared package alu_pkg.
REQ-032 SHALL implement the shift-add/restoring-divide iterator as sub-module alu_mdu_iter (signed/unsigned and mul/div mode inputs, start/done).

Verification
REQ-033 SHALL cover addu regA=0x00000001, regB=0xFFFFFFFE -> result 0xFFFFFFFF, flags 3'b010, latency 1.
REQ-034 SHALL cover addiu regA=0x7FFFFFFF, imm 0x7FFF -> 0x80007FFE, flags 3'b010; addi same operands -> flags 3'b011.
REQ-035 SHALL cover mult regA=-3, regB=5 -> out_valid at cycle 33, LO 0xFFFFFFF1, HI 0xFFFFFFFF; then mfhi -> 0xFFFFFFFF.
REQ-036 SHALL cover div regA=7, regB=-2 -> LO 0xFFFFFFFD, HI 0x00000001; divu 7/0 -> LO 0xFFFFFFFF, HI 0x00000007.
REQ-037 SHALL cover out_ready held low 5 cycles after an and-op -> result/flags stable, in_ready 0 until release.
REQ-038 SHALL cover rst asserted 10 cycles into a mult -> out_valid 0, next mflo returns 0.
